// File: rtl/amba_apb_master.sv
// APB requester: single read/write commands run as SETUP->ACCESS transfers with a response strobe.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module amba_apb_master #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic              pready,
   input  logic [DATA_W-1:0] prdata
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e state_q, state_d;
   logic   abort;

   logic              psel_d, penable_d, pwrite_d, rsp_valid_d, rsp_err_d;
   logic [ADDR_W-1:0] paddr_d;
   logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter is cleared while in SETUP so it starts at zero on ACCESS entry.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == StSetup) begin
         cnt_d = '0;
      end else if (state_q == StAccess && !pready) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   assign abort = (state_q == StAccess) && !pready && (cnt_q == CntW'(TIMEOUT - 1));

   always_ff @(posedge pclk) begin
      if (preset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT == 0);
   assign abort          = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (cmd_valid) state_d = StSetup;
         StSetup:  state_d = StAccess;
         StAccess: if (pready || abort) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      psel_d      = (state_d != StIdle);
      penable_d   = (state_d == StAccess);
      pwrite_d    = pwrite;
      paddr_d     = paddr;
      pwdata_d    = pwdata;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = rsp_rdata;
      if (state_q == StIdle && cmd_valid) begin
         pwrite_d = cmd_write;
         paddr_d  = cmd_addr;
         pwdata_d = cmd_wdata;
      end
      // pready takes priority over a simultaneous timeout hit.
      if (state_q == StAccess && pready) begin
         rsp_valid_d = 1'b1;
         if (!pwrite) rsp_rdata_d = prdata;
      end else if (abort) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = 1'b1;
         rsp_rdata_d = '0;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         psel      <= psel_d;
         penable   <= penable_d;
         pwrite    <= pwrite_d;
         paddr     <= paddr_d;
         pwdata    <= pwdata_d;
         rsp_valid <= rsp_valid_d;
         rsp_err   <= rsp_err_d;
         rsp_rdata <= rsp_rdata_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);

endmodule

// File: tb/tb_amba_apb_master.sv
// Directed bench for amba_apb_master with a behavioural registered-pready APB slave.
module tb_amba_apb_master;

   logic pclk = 1'b0;
   always #5 pclk = ~pclk;

   logic       preset = 1'b1;
   logic       cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [7:0] cmd_addr = '0, cmd_wdata = '0;
   logic       cmd_ready, rsp_valid, rsp_err, psel, penable, pwrite;
   logic [7:0] rsp_rdata, paddr, pwdata, prdata;
   logic       pready = 1'b0;

   logic       c2_valid = 1'b0;
   logic       c2_ready, r2_valid, r2_err, p2_sel, p2_enable, p2_write;
   logic [7:0] r2_rdata, p2_addr, p2_wdata;
   logic       pready2 = 1'b0;
   logic [7:0] prdata2 = 8'h5A;

   int total = 0;
   int bad   = 0;

   // Slave model: pready registered, low for wait_n ACCESS edges, dropped on every SETUP.
   logic [7:0] mem [256];
   int  wait_n  = 1;
   bit  stale   = 1'b0;
   bit  mem_clr = 1'b0;
   int  scnt    = 0;

   assign prdata = mem[paddr];

   always @(posedge pclk) begin
      if (mem_clr) begin
         foreach (mem[i]) mem[i] <= 8'h00;
      end
      if (psel && !penable) begin
         pready <= 1'b0;
         scnt   <= 0;
      end else if (psel && penable) begin
         if (pready) begin
            if (pwrite) mem[paddr] <= pwdata;
            pready <= stale;
         end else begin
            scnt   <= scnt + 1;
            pready <= (scnt + 1 >= wait_n);
         end
      end else if (!stale) begin
         pready <= 1'b0;
      end
   end

   amba_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
      .pclk(pclk), .preset(preset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .prdata(prdata)
   );

   amba_apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) dut_to (
      .pclk(pclk), .preset(preset),
      .cmd_valid(c2_valid), .cmd_ready(c2_ready), .cmd_write(1'b0),
      .cmd_addr(8'h07), .cmd_wdata(8'h00),
      .rsp_valid(r2_valid), .rsp_rdata(r2_rdata), .rsp_err(r2_err),
      .psel(p2_sel), .penable(p2_enable), .pwrite(p2_write), .paddr(p2_addr),
      .pwdata(p2_wdata), .pready(pready2), .prdata(prdata2)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Presents a command at a negedge, returns at the negedge of the SETUP cycle.
   task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d);
      int n = 0;
      cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
      while (!cmd_ready && n < 20) begin
         @(negedge pclk);
         n++;
      end
      total++;
      if (!cmd_ready) begin
         bad++;
         $display("FAIL accept: cmd_ready=%b required 1", cmd_ready);
      end
      @(negedge pclk);
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      preset = 1'b1; mem_clr = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h42; cmd_wdata = 8'h33;
      repeat (2) @(negedge pclk);
      mem_clr = 1'b0;
      total++;
      if ({psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready}
          !== {5'b0, 24'h0, 1'b1}) begin
         bad++;
         $display("FAIL reset_state: got %b/%b/%b/%b/%b %h %h %h rdy=%b required zeros rdy=1",
                  psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready);
      end
      preset = 1'b0; cmd_valid = 1'b0;
      @(negedge pclk);
      total++;
      if (psel !== 1'b0 || paddr !== 8'h00) begin
         bad++;
         $display("FAIL reset_drops_cmd: psel=%b paddr=%h required 0 00", psel, paddr);
      end
   endtask

   task automatic test_write();
      int got = 0;
      issue(1'b1, 8'h05, 8'hA5);
      total++;
      if ({psel, penable, cmd_ready} !== 3'b100) begin
         bad++;
         $display("FAIL wr_setup: psel,penable,ready=%b required 100", {psel, penable, cmd_ready});
      end
      for (int c = 2; c <= 12 && got == 0; c++) begin
         @(negedge pclk);
         if (c == 2) begin
            total++;
            if (penable !== 1'b1) begin
               bad++;
               $display("FAIL wr_penable: penable=%b required 1", penable);
            end
         end
         if (rsp_valid) got = c;
      end
      total++;
      if (got != 4 || rsp_err !== 1'b0) begin
         bad++;
         $display("FAIL wr_rsp: cycle=%0d err=%b required 4 0", got, rsp_err);
      end
      total++;
      if (mem[5] !== 8'hA5) begin
         bad++;
         $display("FAIL wr_mem: mem[5]=%h required a5", mem[5]);
      end
      @(negedge pclk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL wr_pulse: rsp_valid=%b required 0", rsp_valid);
      end
   endtask

   task automatic test_read();
      int got = 0;
      bit pw_ok = 1'b1;
      issue(1'b0, 8'h05, 8'h00);
      if (pwrite !== 1'b0) pw_ok = 1'b0;
      for (int c = 2; c <= 12 && got == 0; c++) begin
         @(negedge pclk);
         if (psel && pwrite !== 1'b0) pw_ok = 1'b0;
         if (rsp_valid) got = c;
      end
      total++;
      if (got != 4 || rsp_rdata !== 8'hA5) begin
         bad++;
         $display("FAIL rd_data: cycle=%0d rdata=%h required 4 a5", got, rsp_rdata);
      end
      total++;
      if (!pw_ok) begin
         bad++;
         $display("FAIL rd_pwrite: pwrite seen high required 0");
      end
   endtask

   task automatic test_wait_states();
      int en_cnt = 0, pulses = 0, got = 0;
      bit stable = 1'b1;
      wait_n = 5;
      issue(1'b1, 8'h3C, 8'h77);
      for (int c = 1; c <= 20; c++) begin
         if (c > 1) @(negedge pclk);
         if (penable) en_cnt++;
         if (psel && (paddr !== 8'h3C || pwdata !== 8'h77)) stable = 1'b0;
         if (rsp_valid) begin
            pulses++;
            got = c;
         end
      end
      wait_n = 1;
      total++;
      if (en_cnt != 6) begin
         bad++;
         $display("FAIL wait_penable: cycles=%0d required 6", en_cnt);
      end
      total++;
      if (!stable) begin
         bad++;
         $display("FAIL wait_stable: paddr/pwdata changed required stable 3c/77");
      end
      total++;
      if (pulses != 1 || got != 8) begin
         bad++;
         $display("FAIL wait_rsp: pulses=%0d cycle=%0d required 1 8", pulses, got);
      end
      total++;
      if (mem[8'h3C] !== 8'h77) begin
         bad++;
         $display("FAIL wait_mem: mem[3c]=%h required 77", mem[8'h3C]);
      end
   endtask

   task automatic test_back_to_back();
      logic       ps [13];
      logic       pe [13];
      logic       rv [13];
      logic [7:0] pa [13];
      int  acc2 = 0;
      bit  early_ok = 1'b1;
      stale = 1'b1; wait_n = 1;
      cmd_write = 1'b1; cmd_addr = 8'h10; cmd_wdata = 8'h11; cmd_valid = 1'b1;
      @(negedge pclk);
      cmd_addr = 8'h11; cmd_wdata = 8'h22;
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) @(negedge pclk);
         ps[c] = psel; pe[c] = penable; rv[c] = rsp_valid; pa[c] = paddr;
         if (psel && !penable && paddr == 8'h11) cmd_valid = 1'b0;
      end
      stale = 1'b0;
      for (int c = 1; c <= 3; c++) if (ps[c] !== 1'b1 || pa[c] !== 8'h10) early_ok = 1'b0;
      for (int c = 5; c <= 12; c++) if (pe[c] === 1'b1 && pa[c] === 8'h11) acc2++;
      total++;
      if (!early_ok) begin
         bad++;
         $display("FAIL b2b_early: first transfer paddr=%h required 10 cycles 1-3", pa[3]);
      end
      total++;
      if (ps[4] !== 1'b0 || rv[4] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_gap: psel=%b rsp_valid=%b required 0 1", ps[4], rv[4]);
      end
      total++;
      if ({ps[5], pe[5]} !== 2'b10 || pa[5] !== 8'h11) begin
         bad++;
         $display("FAIL b2b_setup2: psel,penable=%b paddr=%h required 10 11",
                  {ps[5], pe[5]}, pa[5]);
      end
      total++;
      if (acc2 != 2 || rv[8] !== 1'b1) begin
         bad++;
         $display("FAIL b2b_access2: access=%0d rsp8=%b required 2 1", acc2, rv[8]);
      end
      total++;
      if (mem[8'h10] !== 8'h11 || mem[8'h11] !== 8'h22) begin
         bad++;
         $display("FAIL b2b_mem: %h %h required 11 22", mem[8'h10], mem[8'h11]);
      end
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      wait_n = 3;
      issue(1'b1, 8'h20, 8'h99);
      repeat (2) @(negedge pclk);
      total++;
      if (penable !== 1'b1 || pwrite !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre: penable=%b pwrite=%b required 1 1", penable, pwrite);
      end
      preset = 1'b1;
      @(negedge pclk);
      preset = 1'b0;
      total++;
      if ({psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready}
          !== {5'b0, 24'h0, 1'b1}) begin
         bad++;
         $display("FAIL rst_mid: got %b/%b/%b/%b/%b %h %h %h rdy=%b required zeros rdy=1",
                  psel, penable, pwrite, rsp_valid, rsp_err, paddr, pwdata, rsp_rdata, cmd_ready);
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge pclk);
         if (rsp_valid) pulses++;
      end
      wait_n = 1;
      total++;
      if (pulses != 0 || mem[8'h20] !== 8'h00) begin
         bad++;
         $display("FAIL rst_abort: pulses=%0d mem[20]=%h required 0 00", pulses, mem[8'h20]);
      end
   endtask

   task automatic test_timeout();
      int got = 0;
      pready2 = 1'b1;
      c2_valid = 1'b1;
      @(negedge pclk);
      c2_valid = 1'b0;
      for (int c = 2; c <= 10 && got == 0; c++) begin
         @(negedge pclk);
         if (r2_valid) got = c;
      end
      total++;
      if (got != 3 || r2_rdata !== 8'h5A || r2_err !== 1'b0) begin
         bad++;
         $display("FAIL to_normal: cycle=%0d rdata=%h err=%b required 3 5a 0",
                  got, r2_rdata, r2_err);
      end
      pready2 = 1'b0;
      got = 0;
      @(negedge pclk);
      c2_valid = 1'b1;
      @(negedge pclk);
      c2_valid = 1'b0;
      for (int c = 2; c <= 52 && got == 0; c++) begin
         @(negedge pclk);
         if (r2_valid) got = c;
      end
`ifdef APB_MASTER_TIMEOUT_EN
      total++;
      if (got != 6 || r2_err !== 1'b1 || r2_rdata !== 8'h00) begin
         bad++;
         $display("FAIL to_abort: cycle=%0d err=%b rdata=%h required 6 1 00",
                  got, r2_err, r2_rdata);
      end
      @(negedge pclk);
      total++;
      if (p2_sel !== 1'b0 || c2_ready !== 1'b1) begin
         bad++;
         $display("FAIL to_idle: psel=%b ready=%b required 0 1", p2_sel, c2_ready);
      end
`else
      total++;
      if (got != 0 || p2_enable !== 1'b1) begin
         bad++;
         $display("FAIL to_none: rsp cycle=%0d penable=%b required none 1", got, p2_enable);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/amba_apb_master.md
# amba_apb_master

APB requester that drives `amba_apb_slave`. It accepts single read or write commands on a simple valid/ready port and runs each one as an APB SETUP→ACCESS transfer. It waits out any slave wait states and returns read data and status on a one-cycle response strobe. It sits between the test/control logic and the APB bus.

## Interface
- `ADDR_W`, 8, APB address width (`paddr`, `cmd_addr`)
- `DATA_W`, 8, APB data width (`pwdata`, `prdata`, `cmd_wdata`, `rsp_rdata`)
- `TIMEOUT`, 16, max ACCESS cycles before abort; only used with `APB_MASTER_TIMEOUT_EN`; must be ≥2
- `pclk`  in  1  clock; all logic on the rising edge
- `preset`  in  1  reset, synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  master idle, command can be accepted
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  transfer address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle pulse, transfer finished
- `rsp_rdata`  out  DATA_W  read data; valid with `rsp_valid` on reads
- `rsp_err`  out  1  transfer aborted by timeout; valid with `rsp_valid`
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pready`  in  1  APB ready from the slave
- `prdata`  in  DATA_W  APB read data from the slave

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered, except that `cmd_ready` = (state==IDLE).
- IDLE: `psel`=0, `penable`=0.
  - If `cmd_valid` is high at an edge, capture `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata` and go to SETUP.
- SETUP: `psel`=1, `penable`=0. Go unconditionally to ACCESS at the next edge. `pready` is ignored in this state; a stale high from the previous transfer is legal.
- ACCESS: `psel`=1, `penable`=1.
  - At each edge, sample `pready`.
  - If `pready` is 1: on a read, register `prdata` into `rsp_rdata`. Pulse `rsp_valid`=1 for the next cycle with `rsp_err`=0. Go to IDLE.
  - If `pready` is 0: stay in ACCESS.
- `pwrite`, `paddr` and `pwdata` stay stable from SETUP through the end of ACCESS. They hold their last values while IDLE.
- On a write response, `rsp_rdata` keeps its previous value.
- `cmd_valid` is ignored in SETUP and ACCESS. The command is not queued; the requester must hold it until `cmd_ready` is seen high.
- `rsp_valid` has no back-pressure. It is high for exactly one cycle per transfer.
- Reset (any state, including mid-ACCESS): next cycle is IDLE.
  - `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_err` = 0; `paddr`, `pwdata`, `rsp_rdata` = 0.
  - No response is generated for the aborted transfer.
- If reset and `cmd_valid` are high at the same edge, reset wins and the command is dropped.

## Timing
- Edge E0 accepts the command.
- Cycle after E0: SETUP. Cycle after that: first ACCESS cycle.
- ACCESS length is N+1 cycles, where N is the number of ACCESS-cycle edges at which `pready` was 0.
- `amba_apb_slave` registers `pready`, so it gives N≥1. The minimum full transfer with that slave is: SETUP 1 cycle + ACCESS 2 cycles; `rsp_valid` appears 4 cycles after E0.
- `cmd_ready` returns high in the same cycle as `rsp_valid`. The next command can therefore be accepted at the edge that ends the `rsp_valid` cycle, which puts one idle bus cycle (`psel`=0) between transfers.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- Defined:
  - A counter of width $clog2(TIMEOUT+1) clears on entry to ACCESS and increments each ACCESS cycle with `pready`=0.
  - When TIMEOUT consecutive ACCESS edges see `pready`=0, the transfer ends and the FSM returns to IDLE.
  - The response is `rsp_valid`=1, `rsp_err`=1, with `rsp_rdata` forced to 0.
  - If `pready`=1 and the timeout hit occur at the same edge, `pready` wins and the transfer completes normally.
- Not defined: the counter is absent, ACCESS waits indefinitely, and `rsp_err` is constant 0.

## Test plan
- Reset, then write addr 0x05 data 0xA5 against `amba_apb_slave`.
  - Required: `psel` rises 1 cycle after accept, `penable` 1 cycle later, `rsp_valid` 4 cycles after accept with `rsp_err`=0, and `mem[5]`=0xA5.
- Read addr 0x05 after that write.
  - Required: `rsp_rdata`=0xA5 on the `rsp_valid` cycle, and `pwrite`=0 throughout.
- Behavioural slave holds `pready`=0 for 5 ACCESS edges.
  - Required: `penable` stays high 6 cycles, `paddr`/`pwdata` are stable, and exactly one `rsp_valid` pulse occurs.
- Back-to-back commands with `cmd_valid` held high; the slave leaves `pready` high during the second SETUP.
  - Required: the second transfer still spends ≥2 cycles in ACCESS, and commands asserted while busy are not accepted early.
- Assert `preset` in the second ACCESS cycle.
  - Required: next cycle all outputs are 0, `cmd_ready`=1, no `rsp_valid`, and slave memory is unchanged by the aborted write.
- With `APB_MASTER_TIMEOUT_EN`, TIMEOUT=4, and `pready` stuck at 0.
  - Required: `rsp_valid`=1, `rsp_err`=1, `rsp_rdata`=0 one cycle after the 4th ACCESS edge, then `psel`=0.
  - Without the macro: no response within 50 cycles.
